// File: rtl/mux_n_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_pipe
//   N-way, WIDTH-bit selector with a registered output and valid/ready flow
//   control. A one-word skid register sits behind the output register so that
//   the block sustains one word per cycle under backpressure while in_ready is
//   driven only from state (no combinational path from out_ready).
//
// Ports
//   clk        in   1         single clock, all state on the rising edge
//   reset      in   1         synchronous, active-high
//   in_data    in   N*WIDTH   input i at bits [i*WIDTH +: WIDTH]
//   sel        in   SEL_W     input index, sampled together with in_valid
//   in_valid   in   1         upstream word present
//   in_ready   out  1         block accepts a word this cycle
//   out_data   out  WIDTH     selected word, registered
//   out_err    out  1         this word had sel >= N (word forced to zero)
//   out_valid  out  1         out_data/out_err valid
//   out_ready  in   1         downstream consumes this cycle
// -----------------------------------------------------------------------------
module mux_n_pipe #(
   parameter int WIDTH = 64,
   parameter int N     = 4,
   parameter int SEL_W = (N > 2) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]   sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_err,
   output logic               out_valid,
   input  logic               out_ready
);

   // Returns {err, word}; an index outside 0..N-1 yields err=1 and a zero word.
   function automatic logic [WIDTH:0] select_word(
      input logic [N*WIDTH-1:0] data_v,
      input logic [SEL_W-1:0]   sel_v
   );
      logic [WIDTH:0] res;
      res = {1'b1, {WIDTH{1'b0}}};
      for (int i = 0; i < N; i++) begin
         if (int'(sel_v) == i) begin
            res = {1'b0, data_v[i*WIDTH +: WIDTH]};
         end
      end
      return res;
   endfunction

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             out_err_q,   out_err_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_err_q,  skid_err_d;
   logic             skid_valid_q, skid_valid_d;

   logic             in_ready_s;
   logic             accept_s;
   logic             load_out_s;
   logic [WIDTH:0]   sel_word_s;

   // Ready depends only on skid occupancy; it is held low while reset is high
   // so nothing is accepted during reset.
   assign in_ready_s = ~skid_valid_q & ~reset;
   assign in_ready   = in_ready_s;
   assign out_data   = out_data_q;
   assign out_err    = out_err_q;
   assign out_valid  = out_valid_q;

   // Next-state logic for the output register and the skid register.
   always_comb begin
      accept_s     = in_valid & in_ready_s;
      load_out_s   = ~out_valid_q | out_ready;
      sel_word_s   = select_word(in_data, sel);
      out_data_d   = out_data_q;
      out_err_d    = out_err_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_err_d   = skid_err_q;
      skid_valid_d = skid_valid_q;

      if (load_out_s) begin
         if (skid_valid_q) begin
            // Oldest word lives in the skid: it moves to the output first.
            out_data_d  = skid_data_q;
            out_err_d   = skid_err_q;
            out_valid_d = 1'b1;
            if (accept_s) begin
               skid_data_d  = sel_word_s[WIDTH-1:0];
               skid_err_d   = sel_word_s[WIDTH];
               skid_valid_d = 1'b1;
            end else begin
               skid_valid_d = 1'b0;
            end
         end else if (accept_s) begin
            out_data_d  = sel_word_s[WIDTH-1:0];
            out_err_d   = sel_word_s[WIDTH];
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         // Output stalled: it holds, and a newly accepted word parks in the skid.
         if (accept_s) begin
            skid_data_d  = sel_word_s[WIDTH-1:0];
            skid_err_d   = sel_word_s[WIDTH];
            skid_valid_d = 1'b1;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
   end

   // State registers with synchronous reset; reset discards any held words.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q   <= {WIDTH{1'b0}};
         out_err_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= {WIDTH{1'b0}};
         skid_err_q   <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_err_q    <= out_err_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_err_q   <= skid_err_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: tb/tb_mux_n_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_n_pipe
//   Self-checking bench for mux_n_pipe. Two instances: N=4 and N=3 (the
//   latter exercises out-of-range selects). Expected words are pushed to a
//   per-instance queue when a word is accepted and popped when the instance
//   emits a word; a stalled output is checked for stability every cycle.
// -----------------------------------------------------------------------------
module tb_mux_n_pipe;

   logic         clk;
   logic         reset;

   logic [255:0] in_data4;
   logic [1:0]   sel4;
   logic         in_valid4;
   logic         in_ready4;
   logic [63:0]  out_data4;
   logic         out_err4;
   logic         out_valid4;
   logic         out_ready4;

   logic [191:0] in_data3;
   logic [1:0]   sel3;
   logic         in_valid3;
   logic         in_ready3;
   logic [63:0]  out_data3;
   logic         out_err3;
   logic         out_valid3;
   logic         out_ready3;

   logic [64:0]  exp4;
   logic [64:0]  exp3;
   logic [64:0]  q4[$];
   logic [64:0]  q3[$];
   logic         st4;
   logic         st3;
   logic [64:0]  hold4;
   logic [64:0]  hold3;

   int checks;
   int failures;

   typedef struct {
      logic [1:0]   sel;
      logic [255:0] data;
      logic [63:0]  exp_data;
      logic         exp_err;
   } vec_t;

   vec_t tbl[8];

   mux_n_pipe #(.WIDTH(64), .N(4)) dut4 (
      .clk(clk), .reset(reset),
      .in_data(in_data4), .sel(sel4), .in_valid(in_valid4), .in_ready(in_ready4),
      .out_data(out_data4), .out_err(out_err4), .out_valid(out_valid4),
      .out_ready(out_ready4)
   );

   mux_n_pipe #(.WIDTH(64), .N(3)) dut3 (
      .clk(clk), .reset(reset),
      .in_data(in_data3), .sel(sel3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
      .out_ready(out_ready3)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference selection: word at index s when s < n, else zero with err set.
   function automatic logic [64:0] model_sel(input logic [255:0] d, input logic [1:0] s, input int n);
      if (int'(s) < n) begin
         return {1'b0, d[s*64 +: 64]};
      end else begin
         return {1'b1, 64'd0};
      end
   endfunction

   task automatic drive4(input logic v, input logic [1:0] s, input logic [255:0] d,
                         input logic [64:0] e, input logic r);
      in_valid4 = v; sel4 = s; in_data4 = d; exp4 = e; out_ready4 = r;
   endtask

   task automatic drive3(input logic v, input logic [1:0] s, input logic [191:0] d,
                         input logic [64:0] e, input logic r);
      in_valid3 = v; sel3 = s; in_data3 = d; exp3 = e; out_ready3 = r;
   endtask

   // One clock: observe handshakes just before the edge, then advance to the
   // following falling edge.
   task automatic step();
      #1;
      if (reset) begin
         q4.delete();
         q3.delete();
         st4 = 1'b0;
         st3 = 1'b0;
      end else begin
         if (st4) begin
            chk("hold_valid4", {64'd0, out_valid4}, 65'd1);
            chk("hold_word4", {out_err4, out_data4}, hold4);
         end
         if (st3) begin
            chk("hold_valid3", {64'd0, out_valid3}, 65'd1);
            chk("hold_word3", {out_err3, out_data3}, hold3);
         end
         if (out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
               checks++; failures++;
               $display("FAIL spurious4: got %h expected no word", {out_err4, out_data4});
            end else begin
               chk("out4", {out_err4, out_data4}, q4.pop_front());
            end
         end
         if (out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
               checks++; failures++;
               $display("FAIL spurious3: got %h expected no word", {out_err3, out_data3});
            end else begin
               chk("out3", {out_err3, out_data3}, q3.pop_front());
            end
         end
         if (in_valid4 && in_ready4) q4.push_back(exp4);
         if (in_valid3 && in_ready3) q3.push_back(exp3);
         st4   = out_valid4 && !out_ready4;
         hold4 = {out_err4, out_data4};
         st3   = out_valid3 && !out_ready3;
         hold3 = {out_err3, out_data3};
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [255:0] rd;
      logic [1:0]   rs;
      logic [1:0]   rs3;
      checks   = 0;
      failures = 0;
      st4 = 1'b0; st3 = 1'b0;
      hold4 = 65'd0; hold3 = 65'd0;

      tbl[0] = '{2'd0, {64'h03, 64'h02, 64'h01, 64'h00}, 64'h00, 1'b0};
      tbl[1] = '{2'd1, {64'h13, 64'h12, 64'h11, 64'h10}, 64'h11, 1'b0};
      tbl[2] = '{2'd2, {64'h23, 64'h22, 64'h21, 64'h20}, 64'h22, 1'b0};
      tbl[3] = '{2'd3, {64'h33, 64'h32, 64'h31, 64'h30}, 64'h33, 1'b0};
      tbl[4] = '{2'd0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 64'h5555_AAAA_5555_AAAA}, 64'h5555_AAAA_5555_AAAA, 1'b0};
      tbl[5] = '{2'd1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 64'h5555_AAAA_5555_AAAA}, 64'h8000_0000_0000_0001, 1'b0};
      tbl[6] = '{2'd2, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 64'h5555_AAAA_5555_AAAA}, 64'h0, 1'b0};
      tbl[7] = '{2'd3, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 64'h5555_AAAA_5555_AAAA}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

      // Reset
      reset = 1'b1;
      drive4(1'b0, 2'd0, 256'd0, 65'd0, 1'b1);
      drive3(1'b0, 2'd0, 192'd0, 65'd0, 1'b1);
      step();
      step();
      chk("rst_valid", {64'd0, out_valid4}, 65'd0);
      chk("rst_data", {1'b0, out_data4}, 65'd0);
      chk("rst_err", {64'd0, out_err4}, 65'd0);
      chk("rst_in_ready", {64'd0, in_ready4}, 65'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", {64'd0, in_ready4}, 65'd1);

      // Single word, latency 1
      drive4(1'b1, 2'd2, {64'h44, 64'hDEAD_BEEF, 64'h22, 64'h11}, {1'b0, 64'hDEAD_BEEF}, 1'b1);
      step();
      drive4(1'b0, 2'd0, 256'd0, 65'd0, 1'b1);
      chk("lat1_valid", {64'd0, out_valid4}, 65'd1);
      chk("lat1_word", {out_err4, out_data4}, {1'b0, 64'hDEAD_BEEF});
      step();
      chk("lat1_empty", {64'd0, out_valid4}, 65'd0);

      // Table-driven streaming, back to back
      for (int i = 0; i < 8; i++) begin
         drive4(1'b1, tbl[i].sel, tbl[i].data, {tbl[i].exp_err, tbl[i].exp_data}, 1'b1);
         chk("stream_in_ready", {64'd0, in_ready4}, 65'd1);
         step();
         chk("stream_word", {out_err4, out_data4}, {tbl[i].exp_err, tbl[i].exp_data});
      end
      drive4(1'b0, 2'd0, 256'd0, 65'd0, 1'b1);
      step();
      chk("stream_drained", {31'd0, 32'(q4.size())}, 65'd0);

      // Backpressure: A to output, B to skid, C refused until skid drains
      drive4(1'b1, 2'd0, {4{64'hA1}}, {1'b0, 64'hA1}, 1'b0);
      step();
      drive4(1'b1, 2'd1, {4{64'hB2}}, {1'b0, 64'hB2}, 1'b0);
      chk("bp_ready_b", {64'd0, in_ready4}, 65'd1);
      step();
      drive4(1'b1, 2'd3, {4{64'hC3}}, {1'b0, 64'hC3}, 1'b0);
      chk("bp_ready_full", {64'd0, in_ready4}, 65'd0);
      chk("bp_hold_a", {out_err4, out_data4}, {1'b0, 64'hA1});
      step();
      drive4(1'b1, 2'd3, {4{64'hC3}}, {1'b0, 64'hC3}, 1'b1);
      chk("bp_ready_release", {64'd0, in_ready4}, 65'd0);
      step();
      chk("bp_out_b", {out_err4, out_data4}, {1'b0, 64'hB2});
      chk("bp_ready_again", {64'd0, in_ready4}, 65'd1);
      step();
      chk("bp_out_c", {out_err4, out_data4}, {1'b0, 64'hC3});
      drive4(1'b0, 2'd0, 256'd0, 65'd0, 1'b1);
      step();
      chk("bp_drained", {31'd0, 32'(q4.size())}, 65'd0);

      // N=3: out-of-range select then a legal one
      drive3(1'b1, 2'd3, {64'h333, 64'h222, 64'h111}, {1'b1, 64'd0}, 1'b1);
      step();
      chk("n3_err_word", {out_err3, out_data3}, {1'b1, 64'd0});
      drive3(1'b1, 2'd1, {64'h333, 64'h222, 64'h111}, {1'b0, 64'h222}, 1'b1);
      step();
      chk("n3_ok_word", {out_err3, out_data3}, {1'b0, 64'h222});
      drive3(1'b0, 2'd0, 192'd0, 65'd0, 1'b1);
      step();

      // Reset with two words held
      drive4(1'b1, 2'd2, {4{64'h5A5A_5A5A_5A5A_5A5A}}, {1'b0, 64'h5A5A_5A5A_5A5A_5A5A}, 1'b0);
      step();
      step();
      drive4(1'b0, 2'd0, 256'd0, 65'd0, 1'b0);
      reset = 1'b1;
      step();
      chk("mid_rst_valid", {64'd0, out_valid4}, 65'd0);
      chk("mid_rst_word", {out_err4, out_data4}, 65'd0);
      chk("mid_rst_in_ready", {64'd0, in_ready4}, 65'd0);
      reset = 1'b0;
      #1;
      chk("mid_rst_ready_after", {64'd0, in_ready4}, 65'd1);
      drive4(1'b1, 2'd3, {64'h7777, 64'h6666, 64'h5555, 64'h4444}, {1'b0, 64'h7777}, 1'b1);
      step();
      chk("mid_rst_fresh", {63'd0, out_valid4, out_err4}, {63'd0, 1'b1, 1'b0});
      chk("mid_rst_fresh_data", {1'b0, out_data4}, {1'b0, 64'h7777});
      drive4(1'b0, 2'd0, 256'd0, 65'd0, 1'b1);
      step();
      chk("mid_rst_empty", {64'd0, out_valid4}, 65'd0);

      // Random traffic against the scoreboard
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom();
         rs  = 2'($urandom_range(0, 3));
         rs3 = 2'($urandom_range(0, 3));
         drive4(($urandom_range(0, 3) != 0), rs, rd, model_sel(rd, rs, 4),
                ($urandom_range(0, 9) < 6));
         drive3(($urandom_range(0, 3) != 0), rs3, rd[191:0],
                model_sel({64'd0, rd[191:0]}, rs3, 3), ($urandom_range(0, 9) < 6));
         step();
      end
      drive4(1'b0, 2'd0, 256'd0, 65'd0, 1'b1);
      drive3(1'b0, 2'd0, 192'd0, 65'd0, 1'b1);
      for (int c = 0; c < 20; c++) begin
         if (q4.size() != 0 || q3.size() != 0) step();
      end
      chk("rand_drain4", {31'd0, 32'(q4.size())}, 65'd0);
      chk("rand_drain3", {31'd0, 32'(q3.size())}, 65'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
